// File: rtl/mor1kx_immu_reload_arb.sv
// Arbitrates instruction-fetch reads and IMMU table-walk reads onto one ibus master port.
// Optional bus-cycle timeout abort is enabled by defining MOR1KX_IMMU_RELOAD_TIMEOUT_EN.
module mor1kx_immu_reload_arb #(
    parameter int OPTION_OPERAND_WIDTH  = 32,
    parameter int OPTION_RELOAD_TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] fetch_adr_i,
    output logic                            fetch_ack_o,
    output logic                            fetch_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] fetch_dat_o,
    input  logic                            tlb_reload_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_addr_i,
    output logic                            tlb_reload_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_data_o,
    output logic                            tlb_reload_err_o,
    output logic                            ibus_req_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
    input  logic                            ibus_ack_i,
    input  logic                            ibus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ibus_dat_i,
    output logic                            busy_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        RELOAD = 3'd2,
        GAP    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic                            issue;
    logic [OPTION_OPERAND_WIDTH-1:0] issue_adr;
    logic                            release_bus;
    logic                            timeout;

`ifdef MOR1KX_IMMU_RELOAD_TIMEOUT_EN
    localparam int CW = $clog2(OPTION_RELOAD_TIMEOUT) + 1;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (issue)
            count <= '0;
        else if (state == FETCH || state == RELOAD || state == DRAIN)
            count <= count + 1'b1;
    end

    assign timeout = (count == CW'(OPTION_RELOAD_TIMEOUT - 1));
`else
    logic timeout_unused;
    assign timeout_unused = OPTION_RELOAD_TIMEOUT[0];
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Bus error takes priority over ack, and ack over timeout, in every bus-owning state.
    always_comb begin
        state_next       = state;
        issue            = 1'b0;
        issue_adr        = tlb_reload_addr_i;
        release_bus      = 1'b0;
        fetch_ack_o      = 1'b0;
        fetch_err_o      = 1'b0;
        tlb_reload_ack_o = 1'b0;
        tlb_reload_err_o = 1'b0;
        case (state)
            IDLE: begin
                if (tlb_reload_req_i) begin
                    issue      = 1'b1;
                    state_next = RELOAD;
                end else if (fetch_req_i) begin
                    issue      = 1'b1;
                    issue_adr  = fetch_adr_i;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (ibus_err_i) begin
                    fetch_err_o = 1'b1;
                    release_bus = 1'b1;
                    state_next  = IDLE;
                end else if (ibus_ack_i) begin
                    fetch_ack_o = 1'b1;
                    release_bus = 1'b1;
                    state_next  = IDLE;
                end else if (timeout) begin
                    fetch_err_o = fetch_req_i;
                    release_bus = 1'b1;
                    state_next  = IDLE;
                end else if (!fetch_req_i) begin
                    state_next = DRAIN;
                end
            end
            RELOAD: begin
                if (ibus_err_i) begin
                    tlb_reload_err_o = 1'b1;
                    release_bus      = 1'b1;
                    state_next       = IDLE;
                end else if (ibus_ack_i) begin
                    tlb_reload_ack_o = 1'b1;
                    release_bus      = 1'b1;
                    state_next       = GAP;
                end else if (timeout) begin
                    tlb_reload_err_o = 1'b1;
                    release_bus      = 1'b1;
                    state_next       = IDLE;
                end
            end
            GAP: begin
                // The IMMU presents its next address here; a waiting fetch must not slip in mid-walk.
                if (tlb_reload_req_i) begin
                    issue      = 1'b1;
                    state_next = RELOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (ibus_err_i || ibus_ack_i || timeout) begin
                    release_bus = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ibus_req_o <= 1'b0;
            ibus_adr_o <= '0;
        end else if (issue) begin
            ibus_req_o <= 1'b1;
            ibus_adr_o <= issue_adr;
        end else if (release_bus) begin
            ibus_req_o <= 1'b0;
        end
    end

    assign fetch_dat_o       = fetch_ack_o ? ibus_dat_i : '0;
    assign tlb_reload_data_o = tlb_reload_ack_o ? ibus_dat_i : '0;
    assign busy_o            = (state != IDLE);

endmodule

// File: tb/tb_mor1kx_immu_reload_arb.sv
// Directed bench for mor1kx_immu_reload_arb: response pulses are checked against a scoreboard queue.
module tb_mor1kx_immu_reload_arb;
    localparam int W = 32;
    localparam int T = 4;
    localparam int OW = 4 + 2 * W;
    localparam logic [3:0] K_FACK = 4'b1000;
    localparam logic [3:0] K_FERR = 4'b0100;
    localparam logic [3:0] K_RACK = 4'b0010;
    localparam logic [3:0] K_RERR = 4'b0001;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         fetch_req = 1'b0;
    logic [W-1:0] fetch_adr = '0;
    logic         fetch_ack, fetch_err;
    logic [W-1:0] fetch_dat;
    logic         reload_req = 1'b0;
    logic [W-1:0] reload_addr = '0;
    logic         reload_ack, reload_err;
    logic [W-1:0] reload_data;
    logic         ibus_req;
    logic [W-1:0] ibus_adr;
    logic         ibus_ack = 1'b0;
    logic         ibus_err = 1'b0;
    logic [W-1:0] ibus_dat = '0;
    logic         busy;

    int passed = 0;
    int total  = 0;
    logic [OW-1:0] exp_q[$];

    mor1kx_immu_reload_arb #(
        .OPTION_OPERAND_WIDTH (W),
        .OPTION_RELOAD_TIMEOUT(T)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req_i      (fetch_req),
        .fetch_adr_i      (fetch_adr),
        .fetch_ack_o      (fetch_ack),
        .fetch_err_o      (fetch_err),
        .fetch_dat_o      (fetch_dat),
        .tlb_reload_req_i (reload_req),
        .tlb_reload_addr_i(reload_addr),
        .tlb_reload_ack_o (reload_ack),
        .tlb_reload_data_o(reload_data),
        .tlb_reload_err_o (reload_err),
        .ibus_req_o       (ibus_req),
        .ibus_adr_o       (ibus_adr),
        .ibus_ack_i       (ibus_ack),
        .ibus_err_i       (ibus_err),
        .ibus_dat_i       (ibus_dat),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic req, input logic [W-1:0] adr, input logic bsy);
        check(tag, OW'({req, bsy, ibus_adr}), OW'({req, bsy, adr}));
    endtask

    task automatic push(input logic [3:0] kind, input logic [W-1:0] data);
        if (kind == K_FACK)
            exp_q.push_back({kind, data, {W{1'b0}}});
        else if (kind == K_RACK)
            exp_q.push_back({kind, {W{1'b0}}, data});
        else
            exp_q.push_back({kind, {2*W{1'b0}}});
    endtask

    // Scoreboard: every response pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst && (fetch_ack || fetch_err || reload_ack || reload_err)) begin
            if (exp_q.size() == 0)
                check("unexpected_resp", {fetch_ack, fetch_err, reload_ack, reload_err, fetch_dat, reload_data}, '0);
            else
                check("resp", {fetch_ack, fetch_err, reload_ack, reload_err, fetch_dat, reload_data}, exp_q.pop_front());
        end
    end

    initial begin
        logic [W-1:0] rnd;
        // Reset
        repeat (3) tick();
        check_bus("reset_bus", 1'b0, '0, 1'b0);
        check("reset_resp", OW'({fetch_ack, fetch_err, reload_ack, reload_err}), '0);
        rst = 1'b1;
        tick();

        // 1: plain fetch, ack after 3 cycles
        fetch_req = 1'b1; fetch_adr = 32'h100;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_bus("fetch_hold", 1'b1, 32'h100, 1'b1);
            tick();
        end
        push(K_FACK, 32'hDEADBEEF);
        ibus_ack = 1'b1; ibus_dat = 32'hDEADBEEF;
        tick();
        ibus_ack = 1'b0; fetch_req = 1'b0;
        check_bus("fetch_done", 1'b0, 32'h100, 1'b0);
        tick();

        // 2: two-level walk with GAP between reads
        reload_req = 1'b1; reload_addr = 32'h2000_0040;
        tick();
        check_bus("walk_l1", 1'b1, 32'h2000_0040, 1'b1);
        tick();
        push(K_RACK, 32'h0040_2000);
        ibus_ack = 1'b1; ibus_dat = 32'h0040_2000;
        tick();
        ibus_ack = 1'b0; reload_addr = 32'h0040_2008;
        check_bus("walk_gap", 1'b0, 32'h2000_0040, 1'b1);
        tick();
        check_bus("walk_l2", 1'b1, 32'h0040_2008, 1'b1);
        rnd = $urandom();
        push(K_RACK, rnd);
        ibus_ack = 1'b1; ibus_dat = rnd;
        tick();
        ibus_ack = 1'b0; reload_req = 1'b0;
        tick();
        check_bus("walk_end", 1'b0, 32'h0040_2008, 1'b0);

        // 3: simultaneous requests, reload first; fetch not granted from GAP
        fetch_req = 1'b1; fetch_adr = 32'h0000_0200;
        reload_req = 1'b1; reload_addr = 32'h3000_0000;
        tick();
        check_bus("prio_reload", 1'b1, 32'h3000_0000, 1'b1);
        push(K_RACK, 32'hCAFE_0001);
        ibus_ack = 1'b1; ibus_dat = 32'hCAFE_0001;
        tick();
        ibus_ack = 1'b0; reload_req = 1'b0;
        check_bus("prio_gap", 1'b0, 32'h3000_0000, 1'b1);
        tick();
        check_bus("prio_idle", 1'b0, 32'h3000_0000, 1'b0);
        tick();
        check_bus("prio_fetch", 1'b1, 32'h0000_0200, 1'b1);
        push(K_FACK, 32'hCAFE_0002);
        ibus_ack = 1'b1; ibus_dat = 32'hCAFE_0002;
        tick();
        ibus_ack = 1'b0; fetch_req = 1'b0;
        tick();

        // 4: reload arrives mid-fetch and waits
        fetch_req = 1'b1; fetch_adr = 32'h300;
        tick();
        reload_req = 1'b1; reload_addr = 32'h500;
        tick();
        check_bus("nopreempt", 1'b1, 32'h300, 1'b1);
        push(K_FACK, 32'h1111_2222);
        ibus_ack = 1'b1; ibus_dat = 32'h1111_2222;
        tick();
        ibus_ack = 1'b0; fetch_req = 1'b0;
        check_bus("nopreempt_idle", 1'b0, 32'h300, 1'b0);
        tick();
        check_bus("nopreempt_rl", 1'b1, 32'h500, 1'b1);
        push(K_RACK, 32'h3333_4444);
        ibus_ack = 1'b1; ibus_dat = 32'h3333_4444;
        tick();
        ibus_ack = 1'b0; reload_req = 1'b0;
        tick();

        // 5: fetch abandoned -> DRAIN swallows the ack
        fetch_req = 1'b1; fetch_adr = 32'h400;
        tick();
        fetch_req = 1'b0;
        tick();
        check_bus("drain_hold", 1'b1, 32'h400, 1'b1);
        ibus_ack = 1'b1; ibus_dat = 32'h5555_5555;
        tick();
        ibus_ack = 1'b0;
        check_bus("drain_done", 1'b0, 32'h400, 1'b0);

        // 6: reload bus error; ack|err in FETCH -> err only; ack in IDLE ignored
        reload_req = 1'b1; reload_addr = 32'h600;
        tick();
        push(K_RERR, '0);
        ibus_err = 1'b1;
        tick();
        ibus_err = 1'b0; reload_req = 1'b0;
        check_bus("rerr_idle", 1'b0, 32'h600, 1'b0);
        fetch_req = 1'b1; fetch_adr = 32'h700;
        tick();
        push(K_FERR, '0);
        ibus_err = 1'b1; ibus_ack = 1'b1; ibus_dat = 32'h7777_7777;
        tick();
        fetch_req = 1'b0;
        tick();
        ibus_err = 1'b0; ibus_ack = 1'b0;
        check_bus("ferr_idle", 1'b0, 32'h700, 1'b0);

`ifdef MOR1KX_IMMU_RELOAD_TIMEOUT_EN
        // Timeout: err on the 4th unanswered bus cycle
        reload_req = 1'b1; reload_addr = 32'h800;
        tick();
        push(K_RERR, '0);
        for (int i = 0; i < T - 1; i++) begin
            check_bus("to_wait", 1'b1, 32'h800, 1'b1);
            tick();
        end
        tick();
        reload_req = 1'b0;
        check_bus("to_abort", 1'b0, 32'h800, 1'b0);
        // Ack on the terminal cycle wins over timeout
        fetch_req = 1'b1; fetch_adr = 32'h900;
        tick();
        repeat (T - 1) tick();
        push(K_FACK, 32'h9999_0000);
        ibus_ack = 1'b1; ibus_dat = 32'h9999_0000;
        tick();
        ibus_ack = 1'b0; fetch_req = 1'b0;
        tick();
`endif

        // Reset mid-RELOAD
        reload_req = 1'b1; reload_addr = 32'hA00;
        tick();
        check_bus("pre_rst", 1'b1, 32'hA00, 1'b1);
        rst = 1'b0; reload_req = 1'b0;
        tick();
        check_bus("mid_rst", 1'b0, '0, 1'b0);
        rst = 1'b1;
        repeat (2) tick();

        check("queue_empty", OW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
